// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to an external 4-bit ALU,
// captures result and flags, and maintains an accumulator and sticky overflow.
module alu_op_sequencer #(
  parameter logic [3:0] ACC_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_op,
  input  logic       in_use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_res,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_res,
  output logic [3:0] out_flags,
  output logic       out_err,
  output logic [3:0] acc,
  output logic       sticky_v
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   legal;
  logic   exec;

  assign in_ready  = (state == IDLE) ||
                     ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign exec      = (state == EXEC);
  assign legal     = !alu_op[3];

  // Next-state logic: a new command may chain straight out of DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = EXEC;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand/opcode registers load only when a command is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      alu_a  <= in_use_acc ? acc : in_a;
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  // Capture the ALU response; illegal opcodes yield a fixed error result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_res   <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
    end else if (exec) begin
      if (legal) begin
        out_res   <= alu_res;
        out_flags <= {alu_c, alu_z, alu_v, alu_n};
        out_err   <= 1'b0;
      end else begin
        out_res   <= 4'b0000;
        out_flags <= 4'b0100;
        out_err   <= 1'b1;
      end
    end
  end

  // Accumulator and sticky overflow; clear op resets both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= ACC_INIT;
      sticky_v <= 1'b0;
    end else if (exec && legal) begin
      if (alu_op == 4'd0) begin
        acc      <= 4'b0000;
        sticky_v <= 1'b0;
      end else begin
        acc      <= alu_res;
        sticky_v <= sticky_v | alu_v;
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter ACC_INIT, default 4'b0000: accumulator value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  sequencer can accept a command this cycle.
REQ-006 in_a, in_b  input  4 each  signed two's-complement operands.
REQ-007 in_op  input  4  ALU opcode: 0 clear, 1 add, 2 sub, 3 and, 4 or, 5 not A, 6 not B, 7 xor; 8-15 illegal.
REQ-008 in_use_acc  input  1  when 1, operand A is taken from the accumulator instead of in_a.
REQ-009 alu_a, alu_b, alu_op  output  4 each  registered operands and opcode driven to the downstream 4-bit ALU.
REQ-010 alu_res  input  4  ALU result.
REQ-011 alu_c, alu_z, alu_v, alu_n  input  1 each  ALU carry, zero, overflow and negative flags.
REQ-012 out_valid  output  1  result and flags held and valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_res  output  4  captured result.
REQ-015 out_flags  output  4  captured flags as {c,z,v,n}.
REQ-016 out_err  output  1  the held result came from an illegal opcode.
REQ-017 acc  output  4  accumulator.
REQ-018 sticky_v  output  1  sticky overflow.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-020 in_ready SHALL be 1 in IDLE, or in DONE when out_ready is 1; otherwise it SHALL be 0.
REQ-021 A command SHALL be accepted when in_valid && in_ready; the FSM then SHALL go to EXEC.
REQ-022 On acceptance, alu_a SHALL load (in_use_acc ? acc : in_a), alu_b SHALL load in_b and alu_op SHALL load in_op.
REQ-023 alu_a, alu_b and alu_op SHALL change only on acceptance and SHALL remain stable through EXEC and DONE.
REQ-024 At the EXEC clock edge, out_res SHALL capture alu_res, out_flags SHALL capture {alu_c,alu_z,alu_v,alu_n}, and the FSM SHALL go to DONE.
REQ-025 At that same edge, acc SHALL load alu_res for legal opcodes.
REQ-026 out_valid SHALL be 1 only in DONE.
REQ-027 Latency SHALL be 2 cycles: out_valid rises on the second edge after acceptance.
REQ-028 Peak throughput SHALL be one command per 2 cycles.
REQ-029 In DONE with out_ready=0, all out_* outputs SHALL hold unchanged, with no limit on how long they hold.
REQ-030 In DONE with out_ready=1: if a new command is accepted the FSM SHALL go to EXEC, otherwise to IDLE.
REQ-031 A command accepted in DONE with in_use_acc=1 SHALL read the acc value already updated by the previous command.
REQ-032 Opcode 0 (clear) SHALL set acc to 0000 and clear sticky_v, regardless of the ALU output.
REQ-033 For any other legal opcode, sticky_v SHALL be set when the captured alu_v=1, and SHALL hold otherwise.
REQ-034 For an illegal opcode (op[3]=1): out_res=0000, out_flags=0100, out_err=1; acc and sticky_v SHALL be unchanged.
REQ-035 For legal opcodes out_err SHALL be 0; out_err SHALL be updated with every new captured result.
REQ-036 The sequencer SHALL hold no command queue; in_ready=0 is the only backpressure mechanism.

Reset
REQ-037 While rst=1, independent of clk: state=IDLE, acc=ACC_INIT, sticky_v=0, out_valid=0, out_res=0, out_flags=0, out_err=0, alu_a=alu_b=alu_op=0.
REQ-038 Reset asserted in EXEC or DONE SHALL discard the in-flight command with no acc update.
REQ-039 The first command SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-040 ADD: a=0011, b=0111, op=1, use_acc=0 -> out_valid 2 edges later; out_res=1010, flags c0 z0 v1 n1, acc=1010, sticky_v=1.
REQ-041 Accumulate: after REQ-040, use_acc=1, b=0011, op=3 -> alu_a=1010; out_res=0010, flags 0000, acc=0010, sticky_v stays 1.
REQ-042 SUB: a=0011, b=0101, op=2 -> out_res=1110, flags c1 z0 v0 n1; then op=0 -> acc=0000, sticky_v=0, z=1.
REQ-043 Backpressure: out_ready=0 for 5 cycles in DONE -> out_* stable and in_ready=0; out_ready=1 with in_valid=1 -> accept same cycle, EXEC next.
REQ-044 Illegal op=1010 -> out_err=1, out_res=0000, out_flags=0100, acc unchanged; next legal op -> out_err=0.
REQ-045 Reset mid-EXEC of an ADD -> immediately out_valid=0, acc=ACC_INIT; no result emitted after rst deasserts.
